// File: rtl/int_ctrl_pkg.sv
// Shared constants for the interrupt controller register window and CP0 interface.
// Pure definitions: no latency, no backpressure.
package int_ctrl_pkg;

   localparam logic [3:0] OFF_PEND = 4'h0;
   localparam logic [3:0] OFF_MASK = 4'h4;
   localparam logic [3:0] OFF_MODE = 4'h8;
   localparam logic [3:0] OFF_ID   = 4'hc;

   localparam int HWINT_W = 6;

endpackage

// File: rtl/int_prio_enc.sv
// Fixed-priority encoder: returns index+1 of the lowest set request, 0 when idle.
// Combinational, zero latency; no backpressure.
module int_prio_enc #(
   parameter int N_SRC = 6
) (
   input  logic [N_SRC-1:0] req,
   output logic [2:0]       id
);

   // Scan from the top so the lowest index is the last to write and wins.
   always_comb begin
      id = 3'd0;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (req[i]) id = 3'(i + 1);
      end
   end

endmodule

// File: rtl/int_ctrl.sv
// Memory-mapped interrupt controller: latches sources, masks them onto hwint, W1C acknowledge.
// Latency: one cycle from source/write to hwint/ack; reads are combinational. No backpressure.
module int_ctrl
   import int_ctrl_pkg::*;
#(
   parameter int          N_SRC = 6,
   parameter logic [31:0] BASE  = 32'h0000_7f20
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [N_SRC-1:0]   irq_src,
   input  logic [31:0]        wr_addr,
   input  logic [3:0]         wr_byteen,
   input  logic [31:0]        wr_data,
   input  logic [31:0]        rd_addr,
   output logic [31:0]        rd_data,
   output logic [HWINT_W-1:0] hwint,
   output logic               ack
);

   localparam logic [29:0] W_BASE = BASE[31:2];
   localparam logic [29:0] W_PEND = W_BASE + {28'd0, OFF_PEND[3:2]};
   localparam logic [29:0] W_MASK = W_BASE + {28'd0, OFF_MASK[3:2]};
   localparam logic [29:0] W_MODE = W_BASE + {28'd0, OFF_MODE[3:2]};
   localparam logic [29:0] W_ID   = W_BASE + {28'd0, OFF_ID[3:2]};

   logic [N_SRC-1:0] pend, mask, mode, prev;
   logic [N_SRC-1:0] set_vec, clr_vec, pm;
   logic             wr_pend, wr_mask, wr_mode, ack_q;
   logic [2:0]       id;
   logic             unused_bits;

   assign wr_pend = (|wr_byteen) && (wr_addr[31:2] == W_PEND);
   assign wr_mask = (wr_byteen == 4'hf) && (wr_addr[31:2] == W_MASK);
   assign wr_mode = (wr_byteen == 4'hf) && (wr_addr[31:2] == W_MODE);

   // Edge-mode bits suppress the set while the previous sample was already high.
   assign set_vec = irq_src & ~(mode & prev);
   assign clr_vec = wr_pend ? wr_data[N_SRC-1:0] : '0;

   always_ff @(posedge clk) begin
      if (!reset) begin
         pend  <= '0;
         mask  <= '0;
         mode  <= '0;
         prev  <= '0;
         ack_q <= 1'b0;
      end else begin
         prev  <= irq_src;
         pend  <= (pend & ~clr_vec) | set_vec;
         ack_q <= wr_pend;
         if (wr_mask) mask <= wr_data[N_SRC-1:0];
         if (wr_mode) mode <= wr_data[N_SRC-1:0];
      end
   end

   assign pm    = pend & mask;
   assign hwint = HWINT_W'(pm);
   assign ack   = ack_q;

   int_prio_enc #(.N_SRC(N_SRC)) u_prio (
      .req (pm),
      .id  (id)
   );

   always_comb begin
      rd_data = 32'd0;
      if      (rd_addr[31:2] == W_PEND) rd_data = 32'(pend);
      else if (rd_addr[31:2] == W_MASK) rd_data = 32'(mask);
      else if (rd_addr[31:2] == W_MODE) rd_data = 32'(mode);
      else if (rd_addr[31:2] == W_ID)   rd_data = 32'(id);
   end

   assign unused_bits = ^{wr_addr[1:0], rd_addr[1:0], wr_data};

endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl: inputs driven and outputs sampled on the falling edge.
module tb_int_ctrl;
   localparam logic [31:0] BASE = 32'h0000_7f20;

   logic        clk = 1'b0;
   logic        reset;
   logic [5:0]  irq_src;
   logic [31:0] wr_addr, wr_data, rd_addr, rd_data;
   logic [3:0]  wr_byteen;
   logic [5:0]  hwint;
   logic        ack;
   logic [31:0] v;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   int_ctrl #(.N_SRC(6), .BASE(BASE)) dut (
      .clk(clk), .reset(reset), .irq_src(irq_src),
      .wr_addr(wr_addr), .wr_byteen(wr_byteen), .wr_data(wr_data),
      .rd_addr(rd_addr), .rd_data(rd_data), .hwint(hwint), .ack(ack)
   );

   // One bus write lasting one cycle; returns on the following falling edge.
   task automatic wr(input logic [31:0] off, input logic [3:0] be, input logic [31:0] d);
      wr_addr = BASE + off; wr_byteen = be; wr_data = d;
      @(negedge clk);
      wr_byteen = 4'h0; wr_data = 32'd0;
   endtask

   task automatic rd(input logic [31:0] off, output logic [31:0] r);
      rd_addr = BASE + off;
      #1 r = rd_data;
   endtask

   task automatic test_reset;
      reset = 1'b0; irq_src = 6'h3f;
      repeat (3) @(negedge clk);
      checks++; if (hwint !== 6'h00) begin errors++; $display("FAIL reset_hwint got %h want 00", hwint); end
      checks++; if (ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %b want 0", ack); end
      for (int o = 0; o < 16; o += 4) begin
         rd(o, v);
         checks++; if (v !== 32'd0) begin errors++; $display("FAIL reset_rd off %0d got %h want 0", o, v); end
      end
      irq_src = 6'h00; reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_edge;
      wr(32'h8, 4'hf, 32'h1);
      wr(32'h4, 4'hf, 32'h1);
      irq_src = 6'h01;
      #1;
      checks++; if (hwint !== 6'h00) begin errors++; $display("FAIL edge_pre got %h want 00", hwint); end
      @(negedge clk);
      checks++; if (hwint !== 6'h01) begin errors++; $display("FAIL edge_hwint got %h want 01", hwint); end
      rd(32'h0, v);
      checks++; if (v !== 32'h1) begin errors++; $display("FAIL edge_pend got %h want 1", v); end
      repeat (2) @(negedge clk);
      wr(32'h0, 4'hf, 32'h1);
      checks++; if (ack !== 1'b1) begin errors++; $display("FAIL edge_ack got %b want 1", ack); end
      checks++; if (hwint !== 6'h00) begin errors++; $display("FAIL edge_clr_hwint got %h want 00", hwint); end
      @(negedge clk);
      checks++; if (ack !== 1'b0) begin errors++; $display("FAIL edge_ack_pulse got %b want 0", ack); end
      rd(32'h0, v);
      checks++; if (v !== 32'h0) begin errors++; $display("FAIL edge_no_refire got %h want 0", v); end
      irq_src = 6'h00;
      @(negedge clk);
   endtask

   task automatic test_level;
      wr(32'h8, 4'hf, 32'h0);
      wr(32'h4, 4'hf, 32'h0);
      irq_src = 6'h04;
      @(negedge clk);
      rd(32'h0, v);
      checks++; if (v !== 32'h4) begin errors++; $display("FAIL lvl_pend got %h want 4", v); end
      checks++; if (hwint !== 6'h00) begin errors++; $display("FAIL lvl_masked got %h want 00", hwint); end
      wr(32'h4, 4'hf, 32'h4);
      checks++; if (hwint !== 6'h04) begin errors++; $display("FAIL lvl_unmask got %h want 04", hwint); end
      wr(32'h0, 4'hf, 32'h4);
      rd(32'h0, v);
      checks++; if (v !== 32'h4) begin errors++; $display("FAIL lvl_reset got %h want 4", v); end
   endtask

   task automatic test_set_clear;
      // bit 3 rises in the very cycle its W1C arrives: set must win
      irq_src = 6'h0c;
      wr(32'h0, 4'hf, 32'h8);
      rd(32'h0, v);
      checks++; if (v !== 32'hc) begin errors++; $display("FAIL setclr got %h want c", v); end
      irq_src = 6'h00;
      @(negedge clk);
      wr(32'h0, 4'hf, 32'h3f);
      rd(32'h0, v);
      checks++; if (v !== 32'h0) begin errors++; $display("FAIL clr_all got %h want 0", v); end
   endtask

   task automatic test_priority;
      wr(32'h4, 4'hf, 32'h3f);
      irq_src = 6'h2a;
      @(negedge clk);
      irq_src = 6'h00;
      @(negedge clk);
      checks++; if (hwint !== 6'h2a) begin errors++; $display("FAIL prio_hwint got %h want 2a", hwint); end
      rd(32'hc, v);
      checks++; if (v !== 32'd2) begin errors++; $display("FAIL prio_id1 got %h want 2", v); end
      wr(32'h0, 4'hf, 32'h2);
      rd(32'hc, v);
      checks++; if (v !== 32'd4) begin errors++; $display("FAIL prio_id3 got %h want 4", v); end
      wr(32'h0, 4'hf, 32'h3f);
      rd(32'hc, v);
      checks++; if (v !== 32'd0) begin errors++; $display("FAIL prio_none got %h want 0", v); end
   endtask

   task automatic test_byteen;
      wr(32'h4, 4'h1, 32'h0);
      rd(32'h4, v);
      checks++; if (v !== 32'h3f) begin errors++; $display("FAIL be_mask got %h want 3f", v); end
      rd(32'h5, v);
      checks++; if (v !== 32'h3f) begin errors++; $display("FAIL low_addr got %h want 3f", v); end
      wr(32'h8, 4'h3, 32'h3f);
      rd(32'h8, v);
      checks++; if (v !== 32'h0) begin errors++; $display("FAIL be_mode got %h want 0", v); end
      wr(32'h4, 4'hf, 32'hffff_ffff);
      rd(32'h4, v);
      checks++; if (v !== 32'h3f) begin errors++; $display("FAIL mask_hi got %h want 3f", v); end
      rd(32'h10, v);
      checks++; if (v !== 32'h0) begin errors++; $display("FAIL unmapped got %h want 0", v); end
      irq_src = 6'h10;
      @(negedge clk);
      irq_src = 6'h00;
      wr(32'h0, 4'h2, 32'h0);
      checks++; if (ack !== 1'b1) begin errors++; $display("FAIL be_ack got %b want 1", ack); end
      rd(32'h0, v);
      checks++; if (v !== 32'h10) begin errors++; $display("FAIL be_pend got %h want 10", v); end
   endtask

   task automatic test_reset_mid;
      reset = 1'b0;
      wr(32'h0, 4'hf, 32'h3f);
      checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rst_ack got %b want 0", ack); end
      rd(32'h4, v);
      checks++; if (v !== 32'h0) begin errors++; $display("FAIL rst_mask got %h want 0", v); end
      reset = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b0; irq_src = '0; wr_addr = '0; wr_byteen = '0; wr_data = '0; rd_addr = '0;
      @(negedge clk);
      test_reset;
      test_edge;
      test_level;
      test_set_clear;
      test_priority;
      test_byteen;
      test_reset_mid;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end
endmodule
